clock_set_controller: RTL and testbench

Sequencing controller for the clock/calendar display path. Turns four debounced push-buttons into the control set consumed by the display controller: `set_mode`, `field_sel`, `display_sel`, `mode` and `blink2Hz`. It also emits one-cycle increment/decrement requests and a timekeeping run-enable for the time/date counters. It sits between the button debouncers and both the counter block and the display controller.

---
 rtl/clock_set_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_clock_set_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// clock_set_controller: turns four debounced buttons into the set-mode control
// set for the display controller, plus inc/dec requests and a run-enable for
// the timekeeping counters.
// Optional feature macro: HOLD_REPEAT_EN (auto-repeat while up/down is held).
module clock_set_controller #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_view,
  output logic       set_mode,
  output logic [1:0] field_sel,
  output logic       display_sel,
  output logic       mode,
  output logic       blink2Hz,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       run_en
);

  localparam int unsigned TO_CYCLES = CLK_HZ * TIMEOUT_S;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES);
  localparam int unsigned BL_CYC    = CLK_HZ / 4;
  localparam int unsigned BL_W      = $clog2(BL_CYC);

  // State encoding doubles as the field_sel code for each state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SET_HI  = 2'b11,
    ST_SET_MID = 2'b10,
    ST_SET_LO  = 2'b01
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_btn_prev;
  logic [TO_W-1:0]   r_to_cnt;
  logic [BL_W-1:0]   r_bl_cnt;
  logic              r_set_mode;
  logic [1:0]        r_field_sel;
  logic              r_display_sel;
  logic              r_mode;
  logic              r_blink;
  logic              r_inc;
  logic              r_dec;
  logic              r_run_en;

  logic              w_set_edge;
  logic              w_up_edge;
  logic              w_down_edge;
  logic              w_view_edge;
  logic              w_any_edge;
  logic              w_in_set;
  logic              w_to_hit;
  logic              w_rep_inc;
  logic              w_rep_dec;
  logic              w_rep_any;
  logic              w_mode_nxt;
  logic              w_disp_nxt;
  logic              w_inc_nxt;
  logic              w_dec_nxt;
  logic              w_enter_set;
  logic              w_set_mode_nxt;
  logic              w_run_nxt;

  assign w_set_edge  = btn_set  & ~r_btn_prev[3];
  assign w_up_edge   = btn_up   & ~r_btn_prev[2];
  assign w_down_edge = btn_down & ~r_btn_prev[1];
  assign w_view_edge = btn_view & ~r_btn_prev[0];
  assign w_any_edge  = w_set_edge | w_up_edge | w_down_edge | w_view_edge;
  assign w_in_set    = (r_state != ST_IDLE);
  assign w_rep_any   = w_rep_inc | w_rep_dec;
  // Timeout only fires on a cycle with no button activity.
  assign w_to_hit    = w_in_set && (r_to_cnt == TO_W'(TO_CYCLES - 1)) &&
                       !w_any_edge && !w_rep_any;

`ifdef HOLD_REPEAT_EN
  localparam int unsigned REP_FIRST = CLK_HZ / 2;
  localparam int unsigned REP_NEXT  = CLK_HZ / 8;
  localparam int unsigned REP_W     = $clog2(REP_FIRST);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_fast;
  logic             w_rep_hold;
  logic             w_rep_fire;

  // Exactly one of up/down held, with no new edge this cycle.
  assign w_rep_hold = w_in_set && (btn_up ^ btn_down) && !w_up_edge &&
                      !w_down_edge && !w_set_edge;
  assign w_rep_fire = w_rep_hold &&
                      (r_rep_fast ? (r_rep_cnt == REP_W'(REP_NEXT - 1))
                                  : (r_rep_cnt == REP_W'(REP_FIRST - 1)));
  assign w_rep_inc  = w_rep_fire & btn_up;
  assign w_rep_dec  = w_rep_fire & btn_down;

  // Hold-repeat timer: long first delay, then short repeat period.
  always_ff @(posedge clk) begin
    if (rst || !w_rep_hold) begin
      r_rep_cnt  <= '0;
      r_rep_fast <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt  <= '0;
      r_rep_fast <= 1'b1;
    end else begin
      r_rep_cnt  <= r_rep_cnt + REP_W'(1);
    end
  end
`else
  assign w_rep_inc = 1'b0;
  assign w_rep_dec = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_disp_nxt  = r_display_sel;
    w_inc_nxt   = 1'b0;
    w_dec_nxt   = 1'b0;
    w_enter_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_set_edge) begin
          w_state_nxt = ST_SET_HI;
          w_disp_nxt  = r_mode;
          w_enter_set = 1'b1;
        end else if (w_view_edge) begin
          w_mode_nxt  = ~r_mode;
        end
      end
      ST_SET_HI: begin
        if (w_set_edge) begin
          w_state_nxt = ST_SET_MID;
          w_enter_set = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SET_MID: begin
        if (w_set_edge) begin
          w_state_nxt = ST_SET_LO;
          w_enter_set = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SET_LO: begin
        if (w_set_edge || w_to_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_in_set && !w_set_edge) begin
      w_inc_nxt = (w_up_edge & ~w_down_edge) | w_rep_inc;
      w_dec_nxt = (w_down_edge & ~w_up_edge) | w_rep_dec;
    end
    w_set_mode_nxt = (w_state_nxt != ST_IDLE);
    w_run_nxt      = !(w_set_mode_nxt && !w_disp_nxt);
  end

  // State and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_btn_prev    <= '0;
      r_set_mode    <= 1'b0;
      r_field_sel   <= 2'b00;
      r_display_sel <= 1'b0;
      r_mode        <= 1'b0;
      r_inc         <= 1'b0;
      r_dec         <= 1'b0;
      r_run_en      <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_btn_prev    <= {btn_set, btn_up, btn_down, btn_view};
      r_set_mode    <= w_set_mode_nxt;
      r_field_sel   <= w_state_nxt;
      r_display_sel <= w_disp_nxt;
      r_mode        <= w_mode_nxt;
      r_inc         <= w_inc_nxt;
      r_dec         <= w_dec_nxt;
      r_run_en      <= w_run_nxt;
    end
  end

  // Idle timeout counter: runs only while editing, cleared by any activity.
  always_ff @(posedge clk) begin
    if (rst || !w_in_set || w_any_edge || w_rep_any || w_to_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // 2 Hz blink; phase restarts so a freshly edited value shows immediately.
  always_ff @(posedge clk) begin
    if (rst || w_enter_set || w_inc_nxt || w_dec_nxt) begin
      r_bl_cnt <= '0;
      r_blink  <= 1'b0;
    end else if (r_bl_cnt == BL_W'(BL_CYC - 1)) begin
      r_bl_cnt <= '0;
      r_blink  <= ~r_blink;
    end else begin
      r_bl_cnt <= r_bl_cnt + BL_W'(1);
    end
  end

  assign set_mode    = r_set_mode;
  assign field_sel   = r_field_sel;
  assign display_sel = r_display_sel;
  assign mode        = r_mode;
  assign blink2Hz    = r_blink;
  assign inc_pulse   = r_inc;
  assign dec_pulse   = r_dec;
  assign run_en      = r_run_en;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with CLK_HZ=8, TIMEOUT_S=2
// (16-cycle timeout, 2-cycle blink half-period).
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_set = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_view = 1'b0;
  logic       set_mode;
  logic [1:0] field_sel;
  logic       display_sel;
  logic       mode;
  logic       blink2Hz;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       run_en;

  int checks = 0;
  int errors = 0;

  clock_set_controller #(.CLK_HZ(8), .TIMEOUT_S(2)) dut (
    .clk(clk), .rst(rst),
    .btn_set(btn_set), .btn_up(btn_up), .btn_down(btn_down), .btn_view(btn_view),
    .set_mode(set_mode), .field_sel(field_sel), .display_sel(display_sel),
    .mode(mode), .blink2Hz(blink2Hz), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .run_en(run_en)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs set after this are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    logic       exp_blink [6];
    exp_blink = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    step();
    step();
    got = {set_mode, field_sel, display_sel, mode, blink2Hz, inc_pulse, dec_pulse, run_en};
    checks++;
    if (got !== 9'b0_00_0_0_0_0_0_1) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", got, 9'b0_00_0_0_0_0_0_1);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (blink2Hz !== exp_blink[i]) begin
        errors++;
        $display("FAIL idle_blink[%0d] got %b want %b", i, blink2Hz, exp_blink[i]);
      end
    end
  endtask

  task automatic test_view_then_set();
    btn_view = 1'b1; step(); btn_view = 1'b0;
    checks++;
    if (mode !== 1'b1) begin errors++; $display("FAIL view_toggle mode got %b want 1", mode); end
    step();
    btn_set = 1'b1; step(); btn_set = 1'b0;
    checks++;
    if ({set_mode, field_sel, display_sel, run_en, blink2Hz} !== 6'b1_11_1_1_0) begin
      errors++;
      $display("FAIL date_enter got %b want %b",
               {set_mode, field_sel, display_sel, run_en, blink2Hz}, 6'b1_11_1_1_0);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      btn_set = 1'b1; step(); btn_set = 1'b0; step();
    end
    checks++;
    if ({set_mode, mode} !== 2'b01) begin
      errors++; $display("FAIL date_exit set_mode,mode got %b want 01", {set_mode, mode});
    end
    btn_view = 1'b1; step(); btn_view = 1'b0; step();
    checks++;
    if (mode !== 1'b0) begin errors++; $display("FAIL view_back mode got %b want 0", mode); end
  endtask

  task automatic test_field_walk();
    logic [1:0] exp_f [4];
    exp_f = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      btn_set = 1'b1; step(); btn_set = 1'b0;
      checks++;
      if ({field_sel, set_mode, run_en, display_sel} !==
          {exp_f[i], (i < 3) ? 1'b1 : 1'b0, (i < 3) ? 1'b0 : 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL field_walk[%0d] field,set,run,disp got %b want %b", i,
                 {field_sel, set_mode, run_en, display_sel},
                 {exp_f[i], (i < 3) ? 1'b1 : 1'b0, (i < 3) ? 1'b0 : 1'b1, 1'b0});
      end
      step();
    end
  endtask

  task automatic test_updown();
    int n_inc;
    int n_dec;
    int exp_inc;
    btn_set = 1'b1; step(); btn_set = 1'b0; step();
    btn_set = 1'b1; step(); btn_set = 1'b0; step();
    // Up held for 10 cycles in SET_MID.
    btn_up = 1'b1;
    n_inc = 0; n_dec = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) begin
        checks++;
        if ({inc_pulse, dec_pulse, blink2Hz} !== 3'b100) begin
          errors++;
          $display("FAIL up_first inc,dec,blink got %b want 100", {inc_pulse, dec_pulse, blink2Hz});
        end
      end
      n_inc += int'(inc_pulse);
      n_dec += int'(dec_pulse);
    end
    btn_up = 1'b0;
    step();
    n_inc += int'(inc_pulse);
    n_dec += int'(dec_pulse);
`ifdef HOLD_REPEAT_EN
    exp_inc = 7;
`else
    exp_inc = 1;
`endif
    checks++;
    if (n_inc != exp_inc || n_dec != 0) begin
      errors++;
      $display("FAIL up_hold inc=%0d dec=%0d want inc=%0d dec=0", n_inc, n_dec, exp_inc);
    end
    checks++;
    if (field_sel !== 2'b10) begin
      errors++; $display("FAIL up_hold_field got %b want 10", field_sel);
    end
    // Up and down together: no pulse.
    btn_up = 1'b1; btn_down = 1'b1;
    n_inc = 0; n_dec = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_inc += int'(inc_pulse);
      n_dec += int'(dec_pulse);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    step();
    n_inc += int'(inc_pulse);
    n_dec += int'(dec_pulse);
    checks++;
    if (n_inc != 0 || n_dec != 0) begin
      errors++; $display("FAIL up_down_both inc=%0d dec=%0d want 0 0", n_inc, n_dec);
    end
    // Set and up together: field advances, no pulse.
    btn_set = 1'b1; btn_up = 1'b1; step(); btn_set = 1'b0; btn_up = 1'b0;
    checks++;
    if ({field_sel, inc_pulse, dec_pulse} !== 4'b01_00) begin
      errors++;
      $display("FAIL set_beats_up field,inc,dec got %b want 0100", {field_sel, inc_pulse, dec_pulse});
    end
    step();
    checks++;
    if (inc_pulse !== 1'b0) begin errors++; $display("FAIL set_beats_up_late inc got %b want 0", inc_pulse); end
    // Down edge in SET_LO.
    btn_down = 1'b1; step(); btn_down = 1'b0;
    checks++;
    if ({inc_pulse, dec_pulse, blink2Hz} !== 3'b010) begin
      errors++;
      $display("FAIL down_edge inc,dec,blink got %b want 010", {inc_pulse, dec_pulse, blink2Hz});
    end
    step();
    checks++;
    if (dec_pulse !== 1'b0) begin errors++; $display("FAIL down_one_cycle dec got %b want 0", dec_pulse); end
    btn_set = 1'b1; step(); btn_set = 1'b0;
    checks++;
    if ({set_mode, field_sel, run_en} !== 4'b0_00_1) begin
      errors++;
      $display("FAIL lo_exit set,field,run got %b want 0001", {set_mode, field_sel, run_en});
    end
    step();
  endtask

  task automatic test_timeout();
    int n;
    btn_set = 1'b1; step(); btn_set = 1'b0;
    n = 0;
    while (set_mode === 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL timeout_cycles got %0d want 16", n); end
    checks++;
    if ({field_sel, run_en} !== 3'b00_1) begin
      errors++; $display("FAIL timeout_exit field,run got %b want 001", {field_sel, run_en});
    end
    // Edge at cycle 15 restarts the count.
    btn_set = 1'b1; step(); btn_set = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (set_mode !== 1'b1) begin errors++; $display("FAIL restart_pre set_mode got %b want 1", set_mode); end
    btn_view = 1'b1; step(); btn_view = 1'b0;
    checks++;
    if ({set_mode, mode} !== 2'b10) begin
      errors++; $display("FAIL restart_edge set,mode got %b want 10", {set_mode, mode});
    end
    n = 0;
    while (set_mode === 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL restart_cycles got %0d want 16", n); end
  endtask

  task automatic test_reset_mid_hold();
    int n_inc;
    btn_set = 1'b1; step(); btn_set = 1'b0; step();
    btn_up = 1'b1;
    n_inc = 0;
    for (int i = 1; i <= 6; i++) begin step(); n_inc += int'(inc_pulse); end
`ifdef HOLD_REPEAT_EN
    checks++;
    if (n_inc != 3) begin errors++; $display("FAIL hold_pre_rst inc=%0d want 3", n_inc); end
`else
    checks++;
    if (n_inc != 1) begin errors++; $display("FAIL hold_pre_rst inc=%0d want 1", n_inc); end
`endif
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({inc_pulse, set_mode, field_sel, run_en} !== 5'b0_0_00_1) begin
      errors++;
      $display("FAIL rst_mid inc,set,field,run got %b want 00001",
               {inc_pulse, set_mode, field_sel, run_en});
    end
    n_inc = 0;
    for (int i = 0; i < 8; i++) begin step(); n_inc += int'(inc_pulse) + int'(set_mode); end
    checks++;
    if (n_inc != 0) begin errors++; $display("FAIL rst_mid_after activity=%0d want 0", n_inc); end
    btn_up = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_view_then_set();
    test_field_walk();
    test_updown();
    test_timeout();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
